dmem_req_ctrl: RTL
==================

// Module: dmem_req_ctrl
// PURPOSE
//  MEM-stage consumer of the control unit's MemRead/MemWr/datomic/is_halt decode.
//  Turns one decoded memory instruction into exactly one dcache request and drives
//  the pipeline stall until dhit. Latches halt and keeps saturating perf counters.
//  Sits between the MEM pipeline latch and the per-core dcache port.
// PARAMETERS
//  CNT_W    32  width of the saturating request and stall counters
//  TIMEOUT  256 REQ-wait cycles before timeout_flag is set; 0 disables the watchdog
// PORTS
//  CLK          in   1      clock; all state updates on the rising edge
//  RST          in   1      synchronous, active-high reset
//  MemRead      in   1      control unit: load at MEM
//  MemWr        in   1      control unit: store at MEM
//  datomic      in   1      control unit: LR/SC access
//  is_halt      in   1      control unit: halt instruction at MEM
//  ext_stall    in   1      a downstream stage holds the pipeline
//  addr         in   32     effective address (word_t)
//  wdat         in   32     store data (word_t)
//  dhit         in   1      dcache request complete
//  dmemload     in   32     dcache read data
//  dmemREN      out  1      dcache read request
//  dmemWEN      out  1      dcache write request
//  dmem_atomic  out  1      forwarded datomic of the in-flight request
//  dmemaddr     out  32     latched request address
//  dmemstore    out  32     latched store data
//  mem_stall    out  1      stall the IF..MEM stages
//  load_data    out  32     captured dmemload
//  load_valid   out  1      load_data valid for the current MEM instruction
//  halt         out  1      sticky core halt
//  err_illegal  out  1      one-cycle pulse: MemRead&MemWr both asserted
//  timeout_flag out  1      sticky watchdog flag
//  req_count    out  CNT_W  completed requests, saturating
//  stall_count  out  CNT_W  cycles with mem_stall high, saturating
// BEHAVIOUR
//  Reset: state=IDLE; every output is 0, including the counters and the latched regs.
//  FSM states: IDLE, REQ, DONE, HALTED.
//  IDLE:
//   - is_halt -> HALTED. Halt takes priority over any mem op in the same cycle.
//   - Else MemRead^MemWr -> REQ. Latch addr, wdat, kind and datomic.
//   - MemRead&MemWr: pulse err_illegal for 1 cycle; no request, no stall; stay IDLE.
//  REQ:
//   - dmemREN/dmemWEN follow the latched kind and come from registers.
//   - dmemaddr, dmemstore and dmem_atomic stay stable until dhit.
//   - dhit -> DONE. For a read, capture dmemload into load_data.
//   - REQ-wait cycles == TIMEOUT (TIMEOUT!=0): set timeout_flag and keep waiting.
//  DONE:
//   - REN and WEN are 0. load_valid=1 for a read. mem_stall=0.
//   - ext_stall=1: hold DONE. The instruction stays in MEM and is not reissued.
//   - ext_stall=0: -> IDLE. load_valid clears.
//  HALTED: terminal until RST. halt=1. No requests. mem_stall=0.
//  mem_stall is combinational: (IDLE & legal mem op & !is_halt) | REQ.
//  Latency: op seen at cycle 0. REQ at 1. Earliest dhit at 1, giving DONE at 2 and IDLE at 3.
//   Minimum stall is 2 cycles.
//  req_count increments on each dhit in REQ. stall_count increments each mem_stall cycle.
//   Both saturate at all-ones and never wrap.
//  dhit outside REQ is ignored.
//  RST in any state, including mid-REQ: REN/WEN are 0 from the next edge. No dhit is counted.
// STRUCTURE
//  cpu_types_pkg gains: dmem_state_t {IDLE,REQ,DONE,HALTED} and dmem_kind_t {DK_RD,DK_WR}.
//   word_t is reused.
//  Sub-module sat_counter #(W): en, RST -> count. Instanced twice, for req and stall.
// TESTING
//  1. Load addr=0x100, dhit at cycle 3, dmemload=0xDEADBEEF -> REN in cycles 1-3.
//     mem_stall in cycles 0-3, load_data=0xDEADBEEF, load_valid in cycle 4, req_count=1.
//  2. Store addr=0x204, wdat=0x12345678, dhit immediate -> WEN for 1 cycle.
//     dmemstore=0x12345678, stall 2 cycles.
//  3. Load completes with ext_stall=1 for 3 cycles -> DONE is held.
//     Exactly one REN burst; req_count=1.
//  4. MemRead=MemWr=1 -> err_illegal pulse, no REN/WEN, mem_stall=0.
//  5. is_halt with MemRead=1 -> halt=1 and sticky, no request. Later ops are ignored until RST.
//  6. TIMEOUT=4, no dhit for 10 cycles -> timeout_flag at the 4th wait cycle.
//     Then RST -> all outputs 0 and REN low on the next edge.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, MEM-stage request FSM states and request kinds.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {IDLE, REQ, DONE, HALTED} dmem_state_t;
  typedef enum logic {DK_RD, DK_WR} dmem_kind_t;

  // Everything captured from the MEM latch when a request is launched.
  typedef struct packed {
    word_t      addr;
    word_t      wdat;
    dmem_kind_t kind;
    logic       atomic;
  } dmem_req_t;

endpackage

// File: rtl/dmem_req_ctrl_sat_counter.sv
// W-bit up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // NOTE: default assignment first so every path drives count_d and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) count_d = count_q + W'(1);
  end

  // NOTE: non-blocking assignments for flops so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/dmem_req_ctrl.sv
// MEM-stage dcache request controller: one request per decoded memory op, stalls
// the pipeline until dhit, latches halt, and keeps saturating perf counters.
module dmem_req_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MemRead,
  input  logic             MemWr,
  input  logic             datomic,
  input  logic             is_halt,
  input  logic             ext_stall,
  input  word_t            addr,
  input  word_t            wdat,
  input  logic             dhit,
  input  word_t            dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             dmem_atomic,
  output word_t            dmemaddr,
  output word_t            dmemstore,
  output logic             mem_stall,
  output word_t            load_data,
  output logic             load_valid,
  output logic             halt,
  output logic             err_illegal,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] req_count,
  output logic [CNT_W-1:0] stall_count
);

  // Wide enough to hold TIMEOUT itself; also valid when the watchdog is disabled.
  localparam int TW = $clog2(TIMEOUT + 2);

  dmem_state_t   state_q, state_d;
  dmem_req_t     req_q, req_d;
  word_t         ldata_q, ldata_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          ren_q, ren_d, wen_q, wen_d;
  logic          ill_q, ill_d, tmo_q, tmo_d;
  logic          mem_op, req_done;

  assign mem_op   = MemRead ^ MemWr;
  assign req_done = (state_q == REQ) && dhit;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_halt) state_d = HALTED;
               else if (mem_op) state_d = REQ;
      REQ:     if (dhit) state_d = DONE;
      DONE:    if (!ext_stall) state_d = IDLE;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_stall  = ((state_q == IDLE) && mem_op && !is_halt) || (state_q == REQ);
    load_valid = (state_q == DONE) && (req_q.kind == DK_RD);
    halt       = (state_q == HALTED);
  end

  // wait_q is the 1-based index of the current REQ cycle, saturating at TIMEOUT.
  always_comb begin
    req_d   = req_q;
    ldata_d = ldata_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    ill_d   = (state_q == IDLE) && !is_halt && MemRead && MemWr;
    if ((state_q == IDLE) && (state_d == REQ)) begin
      req_d  = '{addr: addr, wdat: wdat, kind: (MemWr ? DK_WR : DK_RD), atomic: datomic};
      wait_d = TW'(1);
    end else if ((state_q == REQ) && !dhit && (wait_q < TW'(TIMEOUT))) begin
      wait_d = wait_q + TW'(1);
    end
    if ((TIMEOUT != 0) && (state_d == REQ) && (wait_d == TW'(TIMEOUT))) tmo_d = 1'b1;
    if (req_done && (req_q.kind == DK_RD)) ldata_d = dmemload;
    ren_d = (state_d == REQ) && (req_d.kind == DK_RD);
    wen_d = (state_d == REQ) && (req_d.kind == DK_WR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_q   <= '0;
      ldata_q <= '0;
      wait_q  <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      ill_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      req_q   <= req_d;
      ldata_q <= ldata_d;
      wait_q  <= wait_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      ill_q   <= ill_d;
      tmo_q   <= tmo_d;
    end
  end

  assign dmemREN      = ren_q;
  assign dmemWEN      = wen_q;
  assign dmem_atomic  = req_q.atomic;
  assign dmemaddr     = req_q.addr;
  assign dmemstore    = req_q.wdat;
  assign load_data    = ldata_q;
  assign err_illegal  = ill_q;
  assign timeout_flag = tmo_q;

  sat_counter #(.W(CNT_W)) u_req_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .en    (req_done),
    .count (req_count)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .en    (mem_stall),
    .count (stall_count)
  );

endmodule
